// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 packet router.
// Holds the FSM state encoding, the address values, the header field positions and the default sizes.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        WAIT_TILL_EMPTY,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR
    } router_state_e;

    localparam logic [1:0] ADDR0    = 2'd0;
    localparam logic [1:0] ADDR1    = 2'd1;
    localparam logic [1:0] ADDR2    = 2'd2;
    localparam logic [1:0] ADDR_INV = 2'd3;

    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_LEN_MSB  = 7;

    localparam int FIFO_WIDTH   = 9;
    localparam int HDR_FLAG_BIT = 8;

    localparam int DEFAULT_FIFO_DEPTH = 16;
    localparam int DEFAULT_TIMEOUT    = 30;

endpackage

// File: rtl/router_fifo.sv
// Synchronous 9-bit output FIFO for the router: bit 8 marks the header byte, bits 7:0 are the data.
// The read port is registered, and a flush zeroes both pointers.
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [FIFO_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [7:0]            rd_data_o,
    output logic                  empty_o,
    output logic                  full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wrPtrQ, rdPtrQ;
    logic [FIFO_WIDTH-1:0] mem [DEPTH];
    logic [7:0]            rdDataQ;
    logic                  doWrite, doRead;

    // The extra pointer MSB tells a full FIFO apart from an empty one when the index bits are equal.
    assign empty_o   = (wrPtrQ == rdPtrQ);
    assign full_o    = (wrPtrQ[AW] != rdPtrQ[AW]) && (wrPtrQ[AW-1:0] == rdPtrQ[AW-1:0]);
    assign doWrite   = wr_en_i && !full_o;
    assign doRead    = rd_en_i && !empty_o;
    assign rd_data_o = rdDataQ;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtrQ  <= '0;
            rdPtrQ  <= '0;
            rdDataQ <= '0;
        end else begin
            if (doRead) begin
                rdDataQ <= mem[rdPtrQ[AW-1:0]][7:0];
            end
            if (flush_i) begin
                wrPtrQ <= '0;
                rdPtrQ <= '0;
            end else begin
                if (doWrite) wrPtrQ <= wrPtrQ + 1'b1;
                if (doRead)  rdPtrQ <= rdPtrQ + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (doWrite) begin
            mem[wrPtrQ[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/router_top.sv
// router_top: 1x3 byte router that steers each packet into one of three output FIFOs by its header address.
// When ROUTER_SOFT_RESET_EN is defined, the router flushes any output that stays valid and unread for TIMEOUT cycles.
module router_top
    import router_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic [7:0] data_in,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       error,
    output logic       busy,
    output logic [7:0] data_out_0,
    output logic [7:0] data_out_1,
    output logic [7:0] data_out_2
);

    router_state_e         stateQ, stateD;
    logic [1:0]            addrQ, addrD, tgtAddr;
    logic [7:0]            hdrQ, hdrD, parityQ, parityD, rxParityQ, rxParityD, holdDataQ, holdDataD;
    logic                  holdValidQ, holdValidD, mismatchQ, mismatchD, errorQ, errorD;
    logic [2:0]            fifoEmpty, fifoFull, fifoFlush, readEnb;
    logic [7:0]            fifoDout [3];
    logic                  wrEn, tgtEmpty, tgtFull, abortWrite;
    logic [FIFO_WIDTH-1:0] wrData;

    assign readEnb = {read_enb_2, read_enb_1, read_enb_0};

`ifdef ROUTER_SOFT_RESET_EN
    localparam int CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] staleCntQ [3];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) staleCntQ[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (fifoEmpty[i] || readEnb[i] || fifoFlush[i]) staleCntQ[i] <= '0;
                else                                              staleCntQ[i] <= staleCntQ[i] + 1'b1;
            end
        end
    end

    always_comb begin
        fifoFlush = '0;
        for (int i = 0; i < 3; i++) begin
            fifoFlush[i] = !fifoEmpty[i] && !readEnb[i] && (staleCntQ[i] == CntW'(TIMEOUT - 1));
        end
        abortWrite = fifoFlush[addrQ] &&
                     (stateQ inside {LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL});
    end
`else
    assign fifoFlush  = '0;
    assign abortWrite = 1'b0;
`endif

    // While decoding, the live header selects the FIFO; after that, the latched address does.
    always_comb begin
        tgtAddr  = (stateQ == DECODE_ADDRESS) ? data_in[HDR_ADDR_MSB:HDR_ADDR_LSB] : addrQ;
        tgtEmpty = 1'b0;
        tgtFull  = 1'b0;
        case (tgtAddr)
            ADDR0:   begin tgtEmpty = fifoEmpty[0]; tgtFull = fifoFull[0]; end
            ADDR1:   begin tgtEmpty = fifoEmpty[1]; tgtFull = fifoFull[1]; end
            ADDR2:   begin tgtEmpty = fifoEmpty[2]; tgtFull = fifoFull[2]; end
            default: ;
        endcase
    end

    always_comb begin
        stateD     = stateQ;
        addrD      = addrQ;
        hdrD       = hdrQ;
        parityD    = parityQ;
        rxParityD  = rxParityQ;
        holdDataD  = holdDataQ;
        holdValidD = holdValidQ;
        mismatchD  = mismatchQ;
        errorD     = errorQ;
        wrEn       = 1'b0;
        wrData     = '0;
        busy       = 1'b1;
        case (stateQ)
            DECODE_ADDRESS: begin
                busy = 1'b0;
                if (pkt_valid && data_in[HDR_ADDR_MSB:HDR_ADDR_LSB] != ADDR_INV) begin
                    addrD   = data_in[HDR_ADDR_MSB:HDR_ADDR_LSB];
                    hdrD    = data_in;
                    parityD = data_in;
                    errorD  = 1'b0;
                    stateD  = tgtEmpty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (tgtEmpty) stateD = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: begin
                wrEn   = 1'b1;
                wrData = {1'b1, hdrQ};
                stateD = LOAD_DATA;
            end
            LOAD_DATA: begin
                busy = 1'b0;
                // The source advances here regardless, so a byte that meets a full FIFO is parked until there is room.
                if (tgtFull) begin
                    holdDataD  = data_in;
                    holdValidD = pkt_valid;
                    stateD     = FIFO_FULL_STATE;
                end else begin
                    wrEn   = 1'b1;
                    wrData = {1'b0, data_in};
                    if (pkt_valid) begin
                        parityD = parityQ ^ data_in;
                    end else begin
                        rxParityD = data_in;
                        stateD    = LOAD_PARITY;
                    end
                end
            end
            FIFO_FULL_STATE: begin
                if (!tgtFull) stateD = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                wrEn   = 1'b1;
                wrData = {1'b0, holdDataQ};
                if (holdValidQ) begin
                    parityD = parityQ ^ holdDataQ;
                    stateD  = LOAD_DATA;
                end else begin
                    rxParityD = holdDataQ;
                    stateD    = LOAD_PARITY;
                end
            end
            LOAD_PARITY: begin
                mismatchD = (parityQ != rxParityQ);
                stateD    = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                errorD = mismatchQ;
                stateD = DECODE_ADDRESS;
            end
            default: stateD = DECODE_ADDRESS;
        endcase
        if (abortWrite) begin
            wrEn   = 1'b0;
            stateD = DECODE_ADDRESS;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stateQ     <= DECODE_ADDRESS;
            addrQ      <= '0;
            hdrQ       <= '0;
            parityQ    <= '0;
            rxParityQ  <= '0;
            holdDataQ  <= '0;
            holdValidQ <= 1'b0;
            mismatchQ  <= 1'b0;
            errorQ     <= 1'b0;
        end else begin
            stateQ     <= stateD;
            addrQ      <= addrD;
            hdrQ       <= hdrD;
            parityQ    <= parityD;
            rxParityQ  <= rxParityD;
            holdDataQ  <= holdDataD;
            holdValidQ <= holdValidD;
            mismatchQ  <= mismatchD;
            errorQ     <= errorD;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : gFifo
        router_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
            .clk_i     (clk),
            .rst_ni    (resetn),
            .flush_i   (fifoFlush[g]),
            .wr_en_i   (wrEn && (addrQ == 2'(g))),
            .wr_data_i (wrData),
            .rd_en_i   (readEnb[g]),
            .rd_data_o (fifoDout[g]),
            .empty_o   (fifoEmpty[g]),
            .full_o    (fifoFull[g])
        );
    end

    assign vld_out_0  = !fifoEmpty[0];
    assign vld_out_1  = !fifoEmpty[1];
    assign vld_out_2  = !fifoEmpty[2];
    assign data_out_0 = fifoDout[0];
    assign data_out_1 = fifoDout[1];
    assign data_out_2 = fifoDout[2];
    assign error      = errorQ;

endmodule

// File: tb/tb_router_top.sv
// Self-checking bench for router_top: packets with random payloads are checked against per-output byte queues.
// When ROUTER_SOFT_RESET_EN is defined, the bench also checks the stale-output flush.
module tb_router_top;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       pktValid = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic [2:0] rdEnb = 3'b000;
    wire  [2:0] vldOut;
    wire  [7:0] dOut0, dOut1, dOut2;
    wire        errorFlag, busyFlag;

    int         vectors = 0;
    int         misCompares = 0;
    logic [7:0] expQ [3][$];
    int         addrR, lenR;
    bit         corR;

    always #5 clk = ~clk;

    router_top dut (
        .clk        (clk),
        .resetn     (resetn),
        .pkt_valid  (pktValid),
        .read_enb_0 (rdEnb[0]),
        .read_enb_1 (rdEnb[1]),
        .read_enb_2 (rdEnb[2]),
        .data_in    (dataIn),
        .vld_out_0  (vldOut[0]),
        .vld_out_1  (vldOut[1]),
        .vld_out_2  (vldOut[2]),
        .error      (errorFlag),
        .busy       (busyFlag),
        .data_out_0 (dOut0),
        .data_out_1 (dOut1),
        .data_out_2 (dOut2)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            misCompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] doutOf(input int port);
        case (port)
            0:       return dOut0;
            1:       return dOut1;
            default: return dOut2;
        endcase
    endfunction

    // Builds one packet, queues its bytes for the addressed output, and presents each byte until it is taken.
    task automatic applyStimulus(input int addr, input int len, input bit corrupt);
        logic [7:0] pkt [$];
        logic [7:0] par;
        logic [1:0] a2;
        logic [5:0] l6;
        logic       wasBusy;
        int         budget;
        a2 = 2'(addr);
        l6 = 6'(len);
        pkt.push_back({l6, a2});
        for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
        par = 8'h00;
        foreach (pkt[i]) par = par ^ pkt[i];
        if (corrupt) par = par ^ (8'h01 << $urandom_range(7, 0));
        pkt.push_back(par);
        foreach (pkt[i]) expQ[addr].push_back(pkt[i]);
        for (int i = 0; i < pkt.size(); i++) begin
            dataIn   = pkt[i];
            pktValid = (i < pkt.size() - 1);
            budget   = 0;
            wasBusy  = 1'b1;
            while (wasBusy && budget < 500) begin
                @(negedge clk);
                wasBusy = busyFlag;
                @(posedge clk);
                #1;
                budget++;
            end
            if (wasBusy) begin
                checkOutput("send stalled by busy", 32'(wasBusy), 0);
                break;
            end
        end
        pktValid = 1'b0;
        dataIn   = 8'h00;
    endtask

    // Reads an output whenever it is valid and matches each byte against the model queue.
    task automatic checkDrain(input int port, input int count, input string tag);
        int         got = 0;
        int         budget = 0;
        logic [7:0] exp;
        while (got < count && budget < 600) begin
            rdEnb[port] = vldOut[port];
            tick();
            budget++;
            if (rdEnb[port]) begin
                exp = (expQ[port].size() > 0) ? expQ[port].pop_front() : 8'h00;
                checkOutput(tag, 32'(doutOf(port)), 32'(exp));
                got++;
            end
        end
        rdEnb[port] = 1'b0;
        if (got < count) checkOutput({tag, " drain timeout"}, 32'(got), 32'(count));
    endtask

    initial begin
        // Reset values
        resetn = 1'b0;
        tick();
        checkOutput("reset busy", 32'(busyFlag), 0);
        checkOutput("reset error", 32'(errorFlag), 0);
        checkOutput("reset vld", 32'(vldOut), 0);
        checkOutput("reset dout0", 32'(dOut0), 0);
        checkOutput("reset dout1", 32'(dOut1), 0);
        checkOutput("reset dout2", 32'(dOut2), 0);
        resetn = 1'b1;
        tick();

        // Header 0x22: address 2, eight payload bytes, good parity
        applyStimulus(2, 8, 1'b0);
        checkOutput("a2 vld2", 32'(vldOut[2]), 1);
        tick();
        tick();
        checkOutput("a2 error", 32'(errorFlag), 0);
        checkDrain(2, 10, "a2 data");
        checkOutput("a2 vld2 after drain", 32'(vldOut[2]), 0);

        // Corrupted parity raises error two cycles after the parity byte
        applyStimulus(2, 8, 1'b1);
        tick();
        checkOutput("bad parity error early", 32'(errorFlag), 0);
        tick();
        checkOutput("bad parity error", 32'(errorFlag), 1);
        checkDrain(2, 10, "bad parity data");
        applyStimulus(1, 3, 1'b0);
        checkOutput("error cleared by header", 32'(errorFlag), 0);
        tick();
        tick();
        checkDrain(1, 5, "a1 data");
        checkOutput("a1 vld1 after drain", 32'(vldOut[1]), 0);

        // Address 3 headers are dropped
        dataIn   = 8'h0F;
        pktValid = 1'b1;
        tick();
        pktValid = 1'b0;
        dataIn   = 8'h00;
        tick();
        checkOutput("addr3 busy", 32'(busyFlag), 0);
        checkOutput("addr3 vld", 32'(vldOut), 0);

        // A second packet to a non-empty output waits until it drains
        applyStimulus(2, 4, 1'b0);
        fork
            applyStimulus(2, 5, 1'b0);
            begin
                repeat (6) tick();
                checkOutput("wait busy", 32'(busyFlag), 1);
                checkDrain(2, 13, "wait data");
            end
        join
        checkOutput("wait vld2 after drain", 32'(vldOut[2]), 0);
        checkOutput("wait error", 32'(errorFlag), 0);

        // A 20-byte packet overfills FIFO 0 and resumes once reads begin
        fork
            applyStimulus(0, 20, 1'b0);
            begin
                repeat (22) tick();
                checkOutput("full busy", 32'(busyFlag), 1);
                checkOutput("full vld0", 32'(vldOut[0]), 1);
                checkDrain(0, 22, "full data");
            end
        join
        checkOutput("full vld0 after drain", 32'(vldOut[0]), 0);
        checkOutput("full error", 32'(errorFlag), 0);

        // Randomized packets
        for (int n = 0; n < 8; n++) begin
            addrR = $urandom_range(2, 0);
            lenR  = $urandom_range(12, 1);
            corR  = 1'($urandom_range(1, 0));
            applyStimulus(addrR, lenR, corR);
            tick();
            tick();
            checkOutput("rand error", 32'(errorFlag), 32'(corR));
            checkDrain(addrR, lenR + 2, "rand data");
            checkOutput("rand vld after drain", 32'(vldOut), 0);
        end

        // Reset in the middle of a packet discards it
        dataIn   = {6'd5, 2'd1};
        pktValid = 1'b1;
        tick();
        dataIn = 8'($urandom);
        tick();
        tick();
        checkOutput("midreset vld1 before", 32'(vldOut[1]), 1);
        resetn = 1'b0;
        #1;
        checkOutput("midreset vld", 32'(vldOut), 0);
        checkOutput("midreset busy", 32'(busyFlag), 0);
        checkOutput("midreset dout1", 32'(dOut1), 0);
        pktValid = 1'b0;
        dataIn   = 8'h00;
        for (int p = 0; p < 3; p++) expQ[p].delete();
        tick();
        resetn = 1'b1;
        tick();
        checkOutput("after reset busy", 32'(busyFlag), 0);

`ifdef ROUTER_SOFT_RESET_EN
        // An output left unread is flushed 30 cycles after it becomes valid
        fork
            applyStimulus(1, 3, 1'b0);
            begin
                int budget = 0;
                while (!vldOut[1] && budget < 100) begin
                    tick();
                    budget++;
                end
                checkOutput("stale vld1 rose", 32'(vldOut[1]), 1);
                repeat (29) tick();
                checkOutput("stale vld1 before timeout", 32'(vldOut[1]), 1);
                tick();
                checkOutput("stale vld1 flushed", 32'(vldOut[1]), 0);
                checkOutput("stale other outputs", 32'({vldOut[2], vldOut[0]}), 0);
            end
        join
        expQ[1].delete();
        checkOutput("stale busy", 32'(busyFlag), 0);
`else
        // Without the flush option, unread data simply waits
        applyStimulus(1, 3, 1'b0);
        repeat (40) tick();
        checkOutput("idle vld1 held", 32'(vldOut[1]), 1);
        checkDrain(1, 5, "idle data");
        checkOutput("idle vld1 after drain", 32'(vldOut[1]), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misCompares);
        $finish;
    end

endmodule
